preload_sequencer: RTL and testbench
====================================

# preload_sequencer

Host-side driver for the systolic mesh's preload/config port. It accepts a ROWS×COLS weight matrix as a valid/ready stream and issues one preload write per element in row-major order. It then pulses `start` to the FSM controller, waits for `done`, and captures and presents `result_flat` as a single handshaked result. It is the initiating end of the preload interface that the top-level array consumes.

## Interface
Parameters:
- DW, 8, weight/data width
- ROWS, 2, mesh rows
- COLS, 4, mesh columns
- ROW_W, 1, row index width
- COL_W, 2, column index width
- TIMEOUT_W, 8, width of the done-wait watchdog counter (limit = 2^TIMEOUT_W−1 cycles)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  job request, sampled only in IDLE
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accept
- w_data  in  DW  weight value, row-major order
- preload_valid  out  1  preload write strobe to array
- preload_addr  out  ROW_W+COL_W  {row, col}, row in MSBs
- preload_data  out  DW  weight for that address
- start  out  1  one-cycle kick to FSM controller
- done  in  1  completion from FSM controller
- result_flat  in  ROWS*2*DW  array result bus
- res_valid  out  1  captured result available
- res_ready  in  1  result consumer accept
- res_data  out  ROWS*2*DW  captured result
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set when the watchdog expires, cleared by the next accepted go

## Operation
- States: IDLE, LOAD, FIRE, WAIT, HOLD.
- IDLE: w_ready=0. `go`=1 clears the element counter and timeout_err, then moves to LOAD. `go` in any other state is ignored.
- LOAD: w_ready=1. On each beat where w_valid&&w_ready:
  - preload_valid<=1, preload_addr<={row,col}, preload_data<=w_data (registered).
  - col increments; at col=COLS−1, col wraps to 0 and row increments.
  - Accepting element ROWS*COLS−1 drops w_ready the same cycle (combinational from state and count) and moves to FIRE.
- No-beat cycles drive preload_valid=0. preload_addr/data hold their last values.
- FIRE: exactly one cycle with start=1, then WAIT. Watchdog is cleared.
- WAIT: `done`=1 captures result_flat into res_data, asserts res_valid, and moves to HOLD. Otherwise the watchdog increments; at all-ones it sets timeout_err and returns to IDLE with no result.
- HOLD: res_valid stays 1 with res_data stable until res_ready=1. Then res_valid<=0 and the state returns to IDLE.
- `done` outside WAIT is ignored.
- Reset (any time, including mid-LOAD):
  - state IDLE, counters 0.
  - preload_valid, start, w_ready, res_valid, busy, timeout_err all 0.
  - preload_addr, preload_data, res_data all 0.
  - A partial matrix is abandoned; the next job reloads every element.

## Timing
- Accept on edge N → preload_valid high in cycle N+1 (1-cycle latency, one write per accepted beat, back-to-back at full rate).
- Last accept at edge N → last preload_valid in cycle N+1, start in cycle N+1 (FIRE state, registered outputs). The array sees the final write on the same edge start is sampled. Its preload port is write-before-use, so this is legal.
- done sampled at edge M → res_valid high from cycle M+1.
- Minimum job with no stalls: 1 (go) + ROWS*COLS + 1 (FIRE) + array latency + 1 cycles.
- w_valid stalls in LOAD have no timeout; the block waits indefinitely.

## Structure
- Shared package: state encoding (localparam enum of 5 states), address packing function {row,col}, and the ROWS*COLS element-count constant.
- One natural sub-module: `preload_addr_gen`, the row/column counter with wrap and last-element flag.
- FSM, watchdog, and result capture register stay in the parent.

## Test plan
- Reset mid-LOAD after 3 beats → all outputs 0 next cycle; a new go plus 8 beats produces addr sequence 0,1,2,3,4,5,6,7 again.
- ROWS=2, COLS=4, go, then weights 1..8 streamed with no stalls → preload_valid high 8 consecutive cycles with addr 0..7 and data 1..8. start is high only in the cycle of the 8th preload_valid.
- Same job with w_valid toggling every other cycle → 8 writes, correct addr/data, no duplicate or skipped addresses, start exactly once.
- Wired to the array with x={1,2,3,4} and weights 1..8 → res_data row0=30, row1=70. res_valid holds for 5 cycles with res_ready=0, then falls the cycle after res_ready=1.
- done held low after FIRE → timeout_err=1 after 255 WAIT cycles, busy=0, res_valid never asserted. The next go clears timeout_err.
- go pulsed during LOAD and WAIT, and spurious done during LOAD → no state change and no extra start.

Source files
------------

// File: rtl/preload_sequencer_pkg.sv
// Shared definitions for the preload sequencer: default geometry, FSM states
// and the {row,col} address packing used on the preload port.
package preload_sequencer_pkg;

    localparam int DW_DEF        = 8;
    localparam int ROWS_DEF      = 2;
    localparam int COLS_DEF      = 4;
    localparam int ROW_W_DEF     = 1;
    localparam int COL_W_DEF     = 2;
    localparam int TIMEOUT_W_DEF = 8;
    localparam int NUM_ELEMS     = ROWS_DEF * COLS_DEF;
    localparam int ADDR_W_DEF    = ROW_W_DEF + COL_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Row occupies the MSBs so addresses walk row-major as a flat index.
    function automatic logic [ADDR_W_DEF-1:0] pack_addr(input logic [ROW_W_DEF-1:0] row,
                                                        input logic [COL_W_DEF-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/preload_sequencer_if.sv
// Bundle of the weight stream, preload port, controller handshake and result
// stream; master is the sequencer side.
interface preload_sequencer_if #(
    parameter int DW    = 8,
    parameter int ROWS  = 2,
    parameter int ROW_W = 1,
    parameter int COL_W = 2
);
    logic                      w_valid;
    logic                      w_ready;
    logic [DW-1:0]             w_data;
    logic                      preload_valid;
    logic [ROW_W+COL_W-1:0]    preload_addr;
    logic [DW-1:0]             preload_data;
    logic                      start;
    logic                      done;
    logic [ROWS*2*DW-1:0]      result_flat;
    logic                      res_valid;
    logic                      res_ready;
    logic [ROWS*2*DW-1:0]      res_data;

    modport master (
        input  w_valid, w_data, done, result_flat, res_ready,
        output w_ready, preload_valid, preload_addr, preload_data, start, res_valid, res_data
    );

    modport slave (
        output w_valid, w_data, done, result_flat, res_ready,
        input  w_ready, preload_valid, preload_addr, preload_data, start, res_valid, res_data
    );

endinterface

// File: rtl/preload_addr_gen.sv
// Row/column element counter for the preload stream, with wrap and a flag
// marking the final element of the matrix.
module preload_addr_gen
    import preload_sequencer_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    output logic [ROW_W+COL_W-1:0] addr,
    output logic                   last
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_last;

    assign col_last = (col_q == LAST_COL);
    assign last     = col_last && (row_q == LAST_ROW);
    assign addr     = pack_addr(row_q, col_q);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_last) begin
                col_d = '0;
                row_d = last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/preload_sequencer.sv
// Streams a weight matrix into the mesh preload port, kicks the controller,
// then captures the array result behind a done-wait watchdog.
module preload_sequencer
    import preload_sequencer_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int ROW_W     = ROW_W_DEF,
    parameter int COL_W     = COL_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic busy,
    output logic timeout_err,
    preload_sequencer_if.master bus
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int RES_W  = ROWS * 2 * DW;

    state_t state_q, state_d;

    logic              w_ready, start, go_accept, accept, last, wd_expire;
    logic [ADDR_W-1:0] cur_addr;
    logic [TIMEOUT_W-1:0] wd_inc;

    logic                 preload_valid_q, preload_valid_d;
    logic [ADDR_W-1:0]    preload_addr_q,  preload_addr_d;
    logic [DW-1:0]        preload_data_q,  preload_data_d;
    logic [TIMEOUT_W-1:0] wd_q,            wd_d;
    logic                 timeout_err_q,   timeout_err_d;
    logic                 res_valid_q,     res_valid_d;
    logic [RES_W-1:0]     res_data_q,      res_data_d;

    preload_addr_gen #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (go_accept),
        .advance (accept),
        .addr    (cur_addr),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go)                 state_d = ST_LOAD;
            ST_LOAD: if (accept && last)     state_d = ST_FIRE;
            ST_FIRE:                         state_d = ST_WAIT;
            ST_WAIT: if (bus.done)           state_d = ST_HOLD;
                     else if (wd_expire)     state_d = ST_IDLE;
            ST_HOLD: if (bus.res_ready)      state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready   = (state_q == ST_LOAD);
        start     = (state_q == ST_FIRE);
        busy      = (state_q != ST_IDLE);
        go_accept = (state_q == ST_IDLE) && go;
        accept    = w_ready && bus.w_valid;
        wd_inc    = wd_q + TIMEOUT_W'(1);
        wd_expire = (state_q == ST_WAIT) && !bus.done && (&wd_inc);
    end

    // Address/data keep their last value between beats; only the strobe drops.
    always_comb begin
        preload_valid_d = accept;
        preload_addr_d  = accept ? cur_addr   : preload_addr_q;
        preload_data_d  = accept ? bus.w_data : preload_data_q;

        wd_d = wd_q;
        if (state_q == ST_FIRE)                      wd_d = '0;
        else if (state_q == ST_WAIT && !bus.done)    wd_d = wd_inc;

        timeout_err_d = timeout_err_q;
        if (go_accept)      timeout_err_d = 1'b0;
        else if (wd_expire) timeout_err_d = 1'b1;

        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (state_q == ST_WAIT && bus.done) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.result_flat;
        end else if (state_q == ST_HOLD && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preload_valid_q <= 1'b0;
            preload_addr_q  <= '0;
            preload_data_q  <= '0;
            wd_q            <= '0;
            timeout_err_q   <= 1'b0;
            res_valid_q     <= 1'b0;
            res_data_q      <= '0;
        end else begin
            preload_valid_q <= preload_valid_d;
            preload_addr_q  <= preload_addr_d;
            preload_data_q  <= preload_data_d;
            wd_q            <= wd_d;
            timeout_err_q   <= timeout_err_d;
            res_valid_q     <= res_valid_d;
            res_data_q      <= res_data_d;
        end
    end

    assign bus.w_ready       = w_ready;
    assign bus.start         = start;
    assign bus.preload_valid = preload_valid_q;
    assign bus.preload_addr  = preload_addr_q;
    assign bus.preload_data  = preload_data_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_preload_sequencer.sv
// Randomized self-checking bench for preload_sequencer with a behavioural
// mesh model that answers start with a dot-product result after a delay.
module tb_preload_sequencer;

    localparam int DW    = 8;
    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int ROW_W = 1;
    localparam int COL_W = 2;
    localparam int TW    = 8;
    localparam int N     = ROWS * COLS;
    localparam int RW    = ROWS * 2 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0;
    logic busy, timeout_err;

    preload_sequencer_if #(.DW(DW), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W)) bus_if ();

    preload_sequencer #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT_W(TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .busy        (busy),
        .timeout_err (timeout_err),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] wts [N];
    logic [DW-1:0] xv  [COLS];

    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int start_cnt = 0;
    int start_cyc = 0;
    bit res_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the preload port, controller kicks and result strobe mid-cycle.
    always @(negedge clk) begin
        if (bus_if.preload_valid === 1'b1) begin
            wr_addr_q.push_back(int'(bus_if.preload_addr));
            wr_data_q.push_back(int'(bus_if.preload_data));
            wr_cyc_q.push_back(cyc);
        end
        if (bus_if.start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (bus_if.res_valid === 1'b1) res_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        start_cnt = 0;
        res_seen  = 1'b0;
    endtask

    task automatic randomize_job;
        for (int i = 0; i < N; i++)    wts[i] = DW'($urandom);
        for (int c = 0; c < COLS; c++) xv[c]  = DW'($urandom_range(0, 15));
    endtask

    task automatic pulse_go;
        go = 1'b1;
        tick;
        go = 1'b0;
    endtask

    // Expected mesh result: per-row dot product of weights with x, 2*DW bits per row.
    function automatic logic [RW-1:0] model_result();
        logic [RW-1:0] r;
        r = '0;
        for (int ri = 0; ri < ROWS; ri++) begin
            int s;
            s = 0;
            for (int c = 0; c < COLS; c++) s += int'(wts[ri*COLS + c]) * int'(xv[c]);
            r[ri*2*DW +: 2*DW] = (2*DW)'(s);
        end
        return r;
    endfunction

    // What the mesh would compute from the writes it actually received.
    function automatic logic [RW-1:0] array_from_writes();
        int mat [N];
        logic [RW-1:0] r;
        for (int k = 0; k < N; k++) mat[k] = 0;
        for (int k = 0; k < wr_addr_q.size(); k++)
            if (wr_addr_q[k] < N) mat[wr_addr_q[k]] = wr_data_q[k];
        r = '0;
        for (int ri = 0; ri < ROWS; ri++) begin
            int s;
            s = 0;
            for (int c = 0; c < COLS; c++) s += mat[(ri << COL_W) | c] * int'(xv[c]);
            r[ri*2*DW +: 2*DW] = (2*DW)'(s);
        end
        return r;
    endfunction

    // mode 0: full rate, 1: valid every other cycle, 2: random valid.
    task automatic stream(input int n, input int mode, input bit spur);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < n && budget < 400) begin
            if (mode == 0)      bus_if.w_valid = 1'b1;
            else if (mode == 1) bus_if.w_valid = (budget % 2 == 0);
            else                bus_if.w_valid = 1'($urandom_range(0, 1));
            bus_if.w_data = bus_if.w_valid ? wts[i] : DW'($urandom);
            if (spur) begin
                go          = 1'($urandom_range(0, 1));
                bus_if.done = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            acc = bus_if.w_valid && bus_if.w_ready;
            tick;
            if (acc) i++;
            budget++;
        end
        bus_if.w_valid = 1'b0;
        go             = 1'b0;
        bus_if.done    = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("[TB] FAIL stream_accept: accepted %0d beats, required %0d", i, n);
        end
    endtask

    task automatic run_array(input int lat, input bit spur_go);
        int b = 0;
        while (b < 50) begin
            @(negedge clk);
            if (bus_if.start === 1'b1) break;
            b++;
        end
        checks++;
        if (b >= 50) begin
            errors++;
            $display("[TB] FAIL start_seen: start=0 after 50 cycles, required 1");
            return;
        end
        tick;
        for (int j = 0; j < lat; j++) begin
            if (spur_go) go = 1'($urandom_range(0, 1));
            bus_if.result_flat = RW'($urandom);
            tick;
        end
        go                 = 1'b0;
        bus_if.done        = 1'b1;
        bus_if.result_flat = array_from_writes();
        tick;
        bus_if.done        = 1'b0;
        bus_if.result_flat = RW'($urandom);
    endtask

    task automatic check_writes(input bit full_rate);
        int nw;
        nw = wr_addr_q.size();
        checks++;
        if (nw != N) begin
            errors++;
            $display("[TB] FAIL write_count: got %0d writes, required %0d", nw, N);
        end
        for (int k = 0; k < nw && k < N; k++) begin
            int ea;
            ea = ((k / COLS) << COL_W) | (k % COLS);
            checks++;
            if (wr_addr_q[k] != ea || wr_data_q[k] != int'(wts[k])) begin
                errors++;
                $display("[TB] FAIL write_%0d: got addr %0d data %0d, required addr %0d data %0d",
                         k, wr_addr_q[k], wr_data_q[k], ea, wts[k]);
            end
            if (full_rate) begin
                checks++;
                if (wr_cyc_q[k] != wr_cyc_q[0] + k) begin
                    errors++;
                    $display("[TB] FAIL write_gap_%0d: got cycle %0d, required %0d",
                             k, wr_cyc_q[k], wr_cyc_q[0] + k);
                end
            end
        end
        checks++;
        if (start_cnt != 1) begin
            errors++;
            $display("[TB] FAIL start_count: got %0d, required 1", start_cnt);
        end
        if (nw > 0) begin
            checks++;
            if (start_cyc != wr_cyc_q[nw-1]) begin
                errors++;
                $display("[TB] FAIL start_cycle: got %0d, required %0d", start_cyc, wr_cyc_q[nw-1]);
            end
        end
    endtask

    task automatic check_hold(input logic [RW-1:0] exp, input int hold);
        bus_if.res_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== exp) begin
                errors++;
                $display("[TB] FAIL res_hold_%0d: got valid %b data %h, required valid 1 data %h",
                         k, bus_if.res_valid, bus_if.res_data, exp);
            end
        end
        @(posedge clk);
        #1;
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== exp) begin
            errors++;
            $display("[TB] FAIL res_accept: got valid %b data %h, required valid 1 data %h",
                     bus_if.res_valid, bus_if.res_data, exp);
        end
        tick;
        bus_if.res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL res_release: got valid %b busy %b, required 0 0", bus_if.res_valid, busy);
        end
    endtask

    task automatic test_reset;
        logic [RW+2*DW+6+ROW_W+COL_W-1:0] obs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {bus_if.w_ready, bus_if.preload_valid, bus_if.start, bus_if.res_valid, busy, timeout_err,
               bus_if.preload_addr, bus_if.preload_data, bus_if.res_data, bus_if.preload_data};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", obs);
        end
        #1;
        rst_n = 1'b1;
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_if.w_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy %b w_ready %b, required 0 0", busy, bus_if.w_ready);
        end
    endtask

    task automatic test_stream_no_stall;
        clear_mon;
        for (int i = 0; i < N; i++) wts[i] = DW'(i + 1);
        for (int c = 0; c < COLS; c++) xv[c] = DW'(c + 1);
        pulse_go;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus_if.w_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_entry: got busy %b w_ready %b, required 1 1", busy, bus_if.w_ready);
        end
        tick;
        stream(N, 0, 1'b0);
        run_array(3, 1'b0);
        check_hold({16'd70, 16'd30}, 5);
        check_writes(1'b1);
    endtask

    task automatic test_stall_toggle;
        logic [RW-1:0] exp;
        clear_mon;
        randomize_job;
        exp = model_result();
        pulse_go;
        stream(N, 1, 1'b0);
        run_array($urandom_range(1, 20), 1'b0);
        check_hold(exp, $urandom_range(0, 4));
        check_writes(1'b0);
        checks++;
        if (bus_if.preload_addr !== 3'(N - 1) || bus_if.preload_data !== wts[N-1]) begin
            errors++;
            $display("[TB] FAIL preload_hold: got addr %0d data %0d, required addr %0d data %0d",
                     bus_if.preload_addr, bus_if.preload_data, N - 1, wts[N-1]);
        end
    endtask

    task automatic test_random_jobs;
        logic [RW-1:0] exp;
        for (int j = 0; j < 3; j++) begin
            clear_mon;
            randomize_job;
            exp = model_result();
            pulse_go;
            stream(N, 2, 1'b0);
            run_array($urandom_range(0, 30), 1'b0);
            check_hold(exp, $urandom_range(0, 3));
            check_writes(1'b0);
        end
    endtask

    task automatic test_timeout;
        int b = 0;
        int n = 0;
        logic [RW-1:0] exp;
        clear_mon;
        randomize_job;
        pulse_go;
        stream(N, 2, 1'b0);
        while (b < 50) begin
            @(negedge clk);
            if (bus_if.start === 1'b1) break;
            b++;
        end
        while (n < 400) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 255) begin
            errors++;
            $display("[TB] FAIL timeout_wait: got %0d WAIT cycles, required 255", n);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_flag: got err %b busy %b, required 1 0", timeout_err, busy);
        end
        checks++;
        if (res_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_no_result: got res_valid seen %b, required 0", res_seen);
        end
        tick;
        pulse_go;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_clear: got err %b busy %b, required 0 1", timeout_err, busy);
        end
        tick;
        clear_mon;
        randomize_job;
        exp = model_result();
        stream(N, 0, 1'b0);
        run_array(5, 1'b0);
        check_hold(exp, 1);
    endtask

    task automatic test_spurious;
        logic [RW-1:0] exp;
        clear_mon;
        randomize_job;
        exp = model_result();
        pulse_go;
        stream(N, 2, 1'b1);
        run_array(10, 1'b1);
        check_hold(exp, 2);
        check_writes(1'b0);
    endtask

    task automatic test_reset_mid_load;
        logic [RW-1:0] exp;
        logic [RW+2*DW+6+ROW_W+COL_W-1:0] obs;
        clear_mon;
        randomize_job;
        pulse_go;
        stream(3, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        obs = {bus_if.w_ready, bus_if.preload_valid, bus_if.start, bus_if.res_valid, busy, timeout_err,
               bus_if.preload_addr, bus_if.preload_data, bus_if.res_data, bus_if.preload_data};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: got %h, required 0", obs);
        end
        tick;
        rst_n = 1'b1;
        tick;
        clear_mon;
        randomize_job;
        exp = model_result();
        pulse_go;
        stream(N, 0, 1'b0);
        run_array(2, 1'b0);
        check_hold(exp, 1);
        check_writes(1'b1);
    endtask

    initial begin
        bus_if.w_valid     = 1'b0;
        bus_if.w_data      = '0;
        bus_if.done        = 1'b0;
        bus_if.result_flat = '0;
        bus_if.res_ready   = 1'b0;
        test_reset;
        test_stream_no_stall;
        test_stall_toggle;
        test_random_jobs;
        test_timeout;
        test_spurious;
        test_reset_mid_load;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
